// File: rtl/q_mult.sv
// q_mult: two-stage pipelined signed fixed-point multiplier (Q(N-Q).Q format).
// The product is rounded half-up, arithmetically shifted by Q and saturated to N bits.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset, clears every register
//   in_valid  - a/b are sampled this cycle
//   a, b      - signed N-bit operands
//   q_result  - rounded, saturated product (holds while out_valid=0)
//   out_valid - q_result/overflow belong to an accepted pair
//   overflow  - q_result was saturated
module q_mult #(
   parameter int unsigned N = 32,
   parameter int unsigned Q = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] q_result,
   output logic         out_valid,
   output logic         overflow
);

   localparam int unsigned PW = 2 * N;
   localparam logic [PW:0]  RndBias = {{PW{1'b0}}, 1'b1} << (Q - 1);
   localparam logic [N-1:0] MaxVal  = {1'b0, {(N - 1){1'b1}}};
   localparam logic [N-1:0] MinVal  = {1'b1, {(N - 1){1'b0}}};

   // Stage 1: exact product
   logic [PW-1:0] prod_d, prod_q;
   logic          vld1_d, vld1_q;

   // Stage 2: round / shift / saturate (combinational)
   logic        [PW:0]  rnd;
   logic signed [PW:0]  shf;
   logic        [N+1:0] top;
   logic        [N-1:0] sat_val;
   logic                sat_ovf;

   // Output register
   logic [N-1:0] res_d, res_q;
   logic         ovf_d, ovf_q;
   logic         ovld_d, ovld_q;

   always_comb begin
      vld1_d = in_valid;
      prod_d = prod_q;
      if (in_valid) begin
         // Sign-extend to 2N so the 2N-bit product is exact.
         prod_d = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
      end
   end

   always_comb begin
      // One extra bit so the rounding bias can never wrap.
      rnd = {prod_q[PW-1], prod_q} + RndBias;
      shf = $signed(rnd) >>> Q;
      // Value fits in N bits iff bits [PW:N-1] are all copies of the sign.
      top = shf[PW:N-1];
      if ((top == '0) || (top == '1)) begin
         sat_val = shf[N-1:0];
         sat_ovf = 1'b0;
      end else begin
         sat_val = shf[PW] ? MinVal : MaxVal;
         sat_ovf = 1'b1;
      end
   end

   always_comb begin
      ovld_d = vld1_q;
      res_d  = res_q;
      ovf_d  = ovf_q;
      if (vld1_q) begin
         res_d = sat_val;
         ovf_d = sat_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         vld1_q <= 1'b0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
         ovld_q <= 1'b0;
      end else begin
         prod_q <= prod_d;
         vld1_q <= vld1_d;
         res_q  <= res_d;
         ovf_q  <= ovf_d;
         ovld_q <= ovld_d;
      end
   end

   assign q_result  = res_q;
   assign overflow  = ovf_q;
   assign out_valid = ovld_q;

endmodule

// File: tb/tb_q_mult.sv
// Self-checking bench for q_mult (N=32, Q=16): directed vector table, random streaming
// against an integer-arithmetic model, and asynchronous reset behaviour.
module tb_q_mult;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] q_result;
   logic        out_valid;
   logic        overflow;

   int n_cmp;
   int n_bad;

   q_mult #(.N(32), .Q(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .q_result (q_result),
      .out_valid(out_valid),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        ovf;
   } vec_t;

   // Reference: exact integer product, +0.5 LSB, floor-divide by 2^16, clamp.
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                 output logic [31:0] r, output logic o);
      longint p;
      longint s;
      p = longint'($signed(ma)) * longint'($signed(mb));
      s = (p + 64'sd32768) >>> 16;
      if (s > 64'sd2147483647) begin
         r = 32'h7FFF_FFFF;
         o = 1'b1;
      end else if (s < -64'sd2147483648) begin
         r = 32'h8000_0000;
         o = 1'b1;
      end else begin
         r = s[31:0];
         o = 1'b0;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one pair in a cycle and check the two-cycle latency plus hold afterwards.
   task automatic run_one(input int idx, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [31:0] exp, input logic eovf);
      @(negedge clk);
      in_valid = 1'b1;
      a = ta;
      b = tb;
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      check($sformatf("vec%0d early out_valid", idx), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d out_valid", idx), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d q_result", idx), q_result, exp);
      check($sformatf("vec%0d overflow", idx), {31'b0, overflow}, {31'b0, eovf});
      @(negedge clk);
      check($sformatf("vec%0d out_valid drop", idx), {31'b0, out_valid}, 32'd0);
      check($sformatf("vec%0d hold", idx), q_result, exp);
   endtask

   vec_t vecs[12];

   initial begin
      logic [31:0] exq[$];
      logic        exo[$];
      logic [31:0] r;
      logic        o;
      logic [31:0] ea;
      logic        eo;
      int          nvalid;

      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;

      vecs[0]  = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0};
      vecs[1]  = '{32'h0000_0100, 32'h0003_0000, 32'h0000_0300, 1'b0};
      vecs[2]  = '{32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0};
      vecs[3]  = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0001_0000, 1'b0};
      vecs[4]  = '{32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0};
      vecs[5]  = '{32'h0000_0001, 32'h0000_7FFF, 32'h0000_0000, 1'b0};
      vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0};
      vecs[7]  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
      vecs[8]  = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
      vecs[10] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[11] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};

      #1;
      check("reset q_result", q_result, 32'd0);
      check("reset overflow", {31'b0, overflow}, 32'd0);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_one(i, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].ovf);

      // Streaming: 24 back-to-back random pairs, mixing small and full-range values.
      nvalid = 0;
      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         if (out_valid) begin
            nvalid++;
            if (exq.size() == 0) begin
               check("stream extra result", 32'd1, 32'd0);
            end else begin
               ea = exq.pop_front();
               eo = exo.pop_front();
               check($sformatf("stream q_result #%0d", nvalid), q_result, ea);
               check($sformatf("stream overflow #%0d", nvalid), {31'b0, overflow}, {31'b0, eo});
            end
         end
         if (i < 24) begin
            in_valid = 1'b1;
            a = (i % 3 == 0) ? $urandom : 32'($signed(16'($urandom)) <<< ($urandom_range(0, 6)));
            b = (i % 4 == 1) ? $urandom : 32'($signed(20'($urandom)));
            model(a, b, r, o);
            exq.push_back(r);
            exo.push_back(o);
         end else begin
            in_valid = 1'b0;
         end
      end
      check("stream out_valid count", 32'(nvalid), 32'd24);
      check("stream results pending", 32'(exq.size()), 32'd0);

      // Mid-flight asynchronous reset: pair enters stage 1, reset lands mid-cycle.
      run_one(20, 32'h7FFF_FFFF, 32'h0100_0000, 32'h7FFF_FFFF, 1'b1);
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h0002_0000;
      b = 32'h0003_0000;
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset q_result", q_result, 32'd0);
      check("async reset overflow", {31'b0, overflow}, 32'd0);
      check("async reset out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid) nvalid++;
      end
      check("no result after reset", 32'(nvalid), 32'd0);

      // Pipeline works again after release.
      run_one(21, 32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
